// File: rtl/pingpong_sram_ctrl_if.sv
// Producer/consumer stream bundle for the ping-pong SRAM controller.
// The master side is the producer+consumer; the slave side is the controller.
interface pingpong_sram_ctrl_if #(
  parameter int unsigned DW = 64
);
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          rd_en;
  logic          rd_avail;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  modport master (
    output wr_valid, wr_data, wr_last, rd_en,
    input  wr_ready, rd_avail, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en,
    output wr_ready, rd_avail, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/pingpong_sram_ctrl.sv
// Two-bank (EVEN/ODD) ping-pong controller: producer fills one bank while the
// consumer drains the other; banks swap roles when filled/drained.
module pingpong_sram_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 64
) (
  input  logic                 CLK,
  input  logic                 reset,
  pingpong_sram_ctrl_if.slave  bus,
  output logic                 CEN_EVEN,
  output logic                 WEN_EVEN,
  output logic [AW-1:0]        A_EVEN,
  output logic                 CEN_ODD,
  output logic                 WEN_ODD,
  output logic [AW-1:0]        A_ODD,
  output logic [DW-1:0]        D,
  input  logic [DW-1:0]        Q_EVEN,
  input  logic [DW-1:0]        Q_ODD
);

  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t    state [2];
  logic [LW-1:0]  len   [2];
  logic           wbank, rbank;
  logic [AW-1:0]  wcnt, rcnt;
  logic           rd_valid_q, rd_last_q, rd_bank_q;

  logic wr_fire, rd_fire, wr_close, rd_close;

  // A write bank is never FULL/DRAINING and a read bank never EMPTY/FILLING,
  // so a same-cycle write and read always hit different banks.
  assign bus.wr_ready = !reset && (state[wbank] == EMPTY || state[wbank] == FILLING);
  assign bus.rd_avail = !reset && (state[rbank] == FULL  || state[rbank] == DRAINING);

  assign wr_fire  = bus.wr_valid && bus.wr_ready;
  assign rd_fire  = bus.rd_en && bus.rd_avail;
  assign wr_close = (wcnt == AW'(DEPTH - 1)) || bus.wr_last;
  assign rd_close = (LW'(rcnt) + LW'(1)) == len[rbank];

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_data  = rd_bank_q ? Q_ODD : Q_EVEN;
  assign D            = bus.wr_data;

  // Bank state machines and write/read pointers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        state[b] <= EMPTY;
        len[b]   <= '0;
      end
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_close) begin
          len[wbank]   <= LW'(wcnt) + LW'(1);
          state[wbank] <= FULL;
          wcnt         <= '0;
          wbank        <= ~wbank;
        end else begin
          state[wbank] <= FILLING;
          wcnt         <= wcnt + AW'(1);
        end
      end
      if (rd_fire) begin
        rd_bank_q <= rbank;
        if (rd_close) begin
          state[rbank] <= EMPTY;
          rcnt         <= '0;
          rbank        <= ~rbank;
        end else begin
          state[rbank] <= DRAINING;
          rcnt         <= rcnt + AW'(1);
        end
      end
      rd_valid_q <= rd_fire;
      rd_last_q  <= rd_fire && rd_close;
    end
  end

  // SRAM pin drive; idle banks sit at CEN=1, WEN=1, A=0.
  always_comb begin
    CEN_EVEN = 1'b1;
    WEN_EVEN = 1'b1;
    A_EVEN   = '0;
    CEN_ODD  = 1'b1;
    WEN_ODD  = 1'b1;
    A_ODD    = '0;
    if (wr_fire) begin
      if (wbank) begin
        CEN_ODD  = 1'b0;
        WEN_ODD  = 1'b0;
        A_ODD    = wcnt;
      end else begin
        CEN_EVEN = 1'b0;
        WEN_EVEN = 1'b0;
        A_EVEN   = wcnt;
      end
    end
    if (rd_fire) begin
      if (rbank) begin
        CEN_ODD = 1'b0;
        A_ODD   = rcnt;
      end else begin
        CEN_EVEN = 1'b0;
        A_EVEN   = rcnt;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_sram_ctrl.sv
// Scoreboard bench for pingpong_sram_ctrl: a packet-level model predicts
// handshakes, SRAM pin activity and the ordered read stream.
module tb_pingpong_sram_ctrl;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 64;

  logic          CLK = 1'b0;
  logic          reset;
  logic          CEN_EVEN, WEN_EVEN, CEN_ODD, WEN_ODD;
  logic [AW-1:0] A_EVEN, A_ODD;
  logic [DW-1:0] D, Q_EVEN, Q_ODD;

  pingpong_sram_ctrl_if #(.DW(DW)) bus();

  pingpong_sram_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .reset(reset), .bus(bus),
    .CEN_EVEN(CEN_EVEN), .WEN_EVEN(WEN_EVEN), .A_EVEN(A_EVEN),
    .CEN_ODD(CEN_ODD), .WEN_ODD(WEN_ODD), .A_ODD(A_ODD),
    .D(D), .Q_EVEN(Q_EVEN), .Q_ODD(Q_ODD)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural SRAM banks
  logic [DW-1:0] mem_e [DEPTH];
  logic [DW-1:0] mem_o [DEPTH];
  always @(posedge CLK) begin
    if (!CEN_EVEN) begin
      if (!WEN_EVEN) mem_e[A_EVEN] <= D;
      else           Q_EVEN <= mem_e[A_EVEN];
    end
    if (!CEN_ODD) begin
      if (!WEN_ODD) mem_o[A_ODD] <= D;
      else          Q_ODD <= mem_o[A_ODD];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: words in write order, closed packet lengths, and
  // packet counters (packet k lives in bank k%2).
  logic [DW-1:0] buf_q [$];
  int            len_q [$];
  int            wi = 0, ri = 0, wpkt = 0, rpkt = 0;
  bit            prev_rs = 1'b0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t sb_q [$];

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic wl,
                      input logic re, input logic rs, output logic wf);
    logic          exp_wr, exp_av, rf, last;
    logic [9:0]    exp_pins, act_pins;
    logic [DW-1:0] rd;
    exp_t          e;
    @(negedge CLK);
    reset        = rs;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.wr_last  = wl;
    bus.rd_en    = re;
    #1;
    exp_wr = !rs && (len_q.size() < 2);
    exp_av = !rs && (len_q.size() > 0);
    wf = wv && exp_wr;
    rf = re && exp_av;
    exp_pins = 10'b11000_11000;
    if (wf) begin
      if (wpkt % 2 == 0) exp_pins[9:5] = {2'b00, 3'(wi)};
      else               exp_pins[4:0] = {2'b00, 3'(wi)};
    end
    if (rf) begin
      if (rpkt % 2 == 0) exp_pins[9:5] = {2'b01, 3'(ri)};
      else               exp_pins[4:0] = {2'b01, 3'(ri)};
    end
    act_pins = {CEN_EVEN, WEN_EVEN, A_EVEN, CEN_ODD, WEN_ODD, A_ODD};
    chk("wr_ready", DW'(bus.wr_ready), DW'(exp_wr));
    chk("rd_avail", DW'(bus.rd_avail), DW'(exp_av));
    chk("sram_pins", DW'(act_pins), DW'(exp_pins));
    if (wf) chk("write_data", D, wd);
    if (prev_rs && !rs) chk("rd_valid_after_reset", DW'(bus.rd_valid), '0);

    if (rs) begin
      buf_q.delete();
      len_q.delete();
      wi = 0; ri = 0; wpkt = 0; rpkt = 0;
    end else begin
      if (rf) begin
        rd   = buf_q.pop_front();
        last = (ri + 1 == len_q[0]);
        e.cyc = cyc; e.d = rd; e.l = last;
        sb_q.push_back(e);
        if (last) begin
          void'(len_q.pop_front());
          ri = 0;
          rpkt++;
        end else ri++;
      end
      if (wf) begin
        buf_q.push_back(wd);
        if (wi == DEPTH - 1 || wl) begin
          len_q.push_back(wi + 1);
          wi = 0;
          wpkt++;
        end else wi++;
      end
    end
    prev_rs = rs;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic l, input logic re);
    logic wf;
    int   n = 0;
    do begin
      step(1'b1, d, l, re, 1'b0, wf);
      n++;
    end while (!wf && n < 40);
    chk("push_accept", DW'(bus.wr_ready), DW'(1'b1));
  endtask

  task automatic drain();
    logic wf;
    int   n = 0;
    while (len_q.size() > 0 && n < 60) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, wf);
      n++;
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, wf);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge CLK) begin
    exp_t e;
    if (bus.rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("rd_valid_unexpected", DW'(bus.rd_valid), '0);
      end else begin
        e = sb_q.pop_front();
        chk("rd_latency", DW'(cyc), DW'(e.cyc + 1));
        chk("rd_data", bus.rd_data, e.d);
        chk("rd_last", DW'(bus.rd_last), DW'(e.l));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          wf, wv, re, pl, have;
    logic [DW-1:0] pw;
    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.rd_en    = 1'b0;

    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1, wf);

    // Fill EVEN with a recognisable ramp, then drain it
    for (int i = 0; i < 8; i++) push_word(64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, wf);
    repeat (8) step(1'b0, '0, 1'b0, 1'b1, 1'b0, wf);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0, wf);

    // Concurrent streaming
    for (int i = 0; i < 64; i++) push_word(rnd64(), 1'b0, 1'b1);
    drain();

    // Both banks full: writes stall until a drain completes
    for (int i = 0; i < 16; i++) push_word(rnd64(), 1'b0, 1'b0);
    repeat (3) step(1'b1, rnd64(), 1'b0, 1'b0, 1'b0, wf);
    repeat (8) step(1'b0, '0, 1'b0, 1'b1, 1'b0, wf);
    push_word(rnd64(), 1'b0, 1'b0);
    push_word(rnd64(), 1'b1, 1'b0);
    drain();

    // Early close on the 3rd word, next word opens the other bank at A=0
    push_word(rnd64(), 1'b0, 1'b0);
    push_word(rnd64(), 1'b0, 1'b0);
    push_word(rnd64(), 1'b1, 1'b0);
    push_word(rnd64(), 1'b1, 1'b0);
    drain();

    // Reset while draining at rcnt=4, with requests held high
    for (int i = 0; i < 8; i++) push_word(rnd64(), 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b0, wf);
    step(1'b1, rnd64(), 1'b0, 1'b1, 1'b1, wf);
    push_word(rnd64(), 1'b1, 1'b0);
    drain();

    // Randomized traffic; producer holds a refused word
    have = 1'b0;
    pw   = '0;
    pl   = 1'b0;
    repeat (800) begin
      if (!have) begin
        pw   = rnd64();
        pl   = ($urandom_range(0, 9) == 0);
        have = 1'b1;
      end
      wv = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 3) != 0);
      step(wv, pw, pl, re, 1'b0, wf);
      if (wf) have = 1'b0;
    end
    drain();
    push_word(rnd64(), 1'b1, 1'b0);
    drain();
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0, wf);
    chk("scoreboard_empty", DW'(sb_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pingpong_sram_ctrl.md
# pingpong_sram_ctrl

Ping-pong controller for the two-bank 64-bit double-buffered activation/weight SRAM (two 8-word banks: EVEN and ODD). A producer fills one bank while a consumer drains the other, and the banks swap roles automatically. The controller generates per-bank active-low CEN/WEN, a 3-bit address per bank and the shared write data. It also muxes the bank read data back to the consumer. It sits between the L0/IFIFO-side producer and the core consumer.

## Interface
- DEPTH, 8: words per bank (power of two, ≤ 8).
- AW, 3: bank address width, log2(DEPTH).
- DW, 64: data width.

- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  controller accepts a word this cycle.
- wr_data  in  DW  producer word.
- wr_last  in  1  qualifies wr_valid; the accepted word closes the current bank early.
- rd_en  in  1  consumer pull request; ignored when rd_avail=0.
- rd_avail  out  1  the current read bank holds unread data.
- rd_valid  out  1  rd_data is valid (registered).
- rd_data  out  DW  word read from the SRAM.
- rd_last  out  1  with rd_valid, last word of the bank.
- CEN_EVEN, WEN_EVEN  out  1 each  EVEN bank enable and write enable (active low).
- A_EVEN  out  AW  EVEN bank address.
- CEN_ODD, WEN_ODD  out  1 each  ODD bank enable and write enable (active low).
- A_ODD  out  AW  ODD bank address.
- D  out  DW  write data to both banks (equals wr_data).
- Q_EVEN, Q_ODD  in  DW each  bank read data, valid the cycle after a read edge.

## Operation
- Each bank has a 2-bit state: EMPTY, FILLING, FULL, DRAINING.
- Each bank has a length register len[b] (AW+1 bits).
- Write pointer: wbank (0=EVEN), wcnt. Read pointer: rbank, rcnt.
- wr_ready = !reset && state[wbank] ∈ {EMPTY, FILLING}.
- Write (wr_valid && wr_ready):
  - Drive bank wbank: CEN=0, WEN=0, A=wcnt.
  - EMPTY→FILLING.
  - If wcnt==DEPTH-1 or wr_last:
    - len[wbank]=wcnt+1.
    - state[wbank]=FULL.
    - wcnt=0, wbank toggles.
  - Otherwise wcnt+1.
- rd_avail = state[rbank] ∈ {FULL, DRAINING}.
- Read (rd_en && rd_avail):
  - Drive bank rbank: CEN=0, WEN=1, A=rcnt.
  - FULL→DRAINING.
  - If rcnt==len[rbank]-1, the issued read is the last one:
    - state[rbank]=EMPTY.
    - rcnt=0, rbank toggles.
    - rd_last is registered high with rd_valid.
  - Otherwise rcnt+1.
- Banks not addressed in a cycle get CEN=1, WEN=1, A=0.
- A write and a read may occur in the same cycle. They always target different banks: the state encoding makes same-bank conflicts impossible.
- If wr_valid is asserted with wr_ready=0, nothing happens and the producer holds its word.
- wr_last on a FILLING bank closes it at the accepted word. A wr_last on the first word gives len=1.
- A bank that becomes EMPTY on edge N can be written from cycle N+1.
- A bank that becomes FULL on edge N can be read from cycle N+1.

## Timing
- Writes are combinational in the request cycle: CEN/WEN/A/D are asserted in the same cycle as the handshake, and the SRAM captures on that edge.
- Read latency is 1:
  - Request accepted in cycle t, SRAM read on edge t.
  - rd_valid=1 in cycle t+1.
  - rd_data = Q of the bank registered in rd_bank_q.
  - rd_data is combinational from Q_EVEN/Q_ODD through the mux.
- Streaming throughput is one word per cycle per side.
- Reset values:
  - all states EMPTY; wbank=rbank=0; wcnt=rcnt=0; len=0.
  - rd_valid=0, rd_last=0, rd_avail=0.
  - all CEN=1, WEN=1, A=0.
  - wr_ready=0 while reset is high, 1 in the first cycle after.
- Reset mid-operation discards all buffered data; no SRAM access is issued during reset.
- There is no backpressure on rd_valid: the consumer must accept rd_data in the cycle rd_valid=1.

## Test plan
- Reset, then 8 writes 0x..00 to 0x..07:
  - EVEN A=0..7 with WEN_EVEN=0.
  - wr_ready stays 1, wbank→ODD.
  - rd_avail=1 the cycle after the 8th write.
- Fill EVEN, then assert rd_en 8 cycles:
  - rd_valid cycles t+1..t+8 with data 0..7.
  - rd_last only on word 7.
  - rd_avail=0 afterwards.
- Concurrent streaming:
  - writes to ODD while EVEN drains.
  - both banks see CEN=0 in the same cycles.
  - no data corruption over 64 words.
- Both banks FULL:
  - wr_valid=1 → wr_ready=0, no WEN asserted.
  - the first EVEN drain completion re-opens writes to EVEN on the next cycle.
- wr_last on the 3rd word:
  - len=3; rd_last on the 3rd read.
  - the next write goes to the other bank at A=0.
- reset asserted while DRAINING at rcnt=4:
  - the next cycle shows all outputs at reset values.
  - a subsequent write lands in EVEN A=0.
